// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: raster pixels in, packed valid-mode windows out.
// Optional `win_last` marker port is enabled by defining WINGEN_LAST_EN.
module conv_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                pix_valid,
    input  logic [DATA_W-1:0]   pix_in,
    output logic                win_valid,
    output logic [9*DATA_W-1:0] win_data,
    output logic                frame_done
`ifdef WINGEN_LAST_EN
    ,
    output logic                win_last
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]       col_q, col_d, cur_col;
    logic [RW-1:0]       row_q, row_d, cur_row;
    logic [DATA_W-1:0]   lb1_q [IMG_W];
    logic [DATA_W-1:0]   lb2_q [IMG_W];
    logic [DATA_W-1:0]   win_q [3][3];
    logic [DATA_W-1:0]   win_d [3][3];
    logic                win_valid_q, win_valid_d;
    logic [9*DATA_W-1:0] win_data_q, win_data_d;
    logic                frame_done_q, frame_done_d;
    logic                emit, frame_end;

    // clr retargets the current cycle to (0,0) so a coincident pixel starts the new frame
    assign cur_col = clr ? '0 : col_q;
    assign cur_row = clr ? '0 : row_q;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        win_d      = win_q;
        win_data_d = win_data_q;
        emit       = 1'b0;
        frame_end  = 1'b0;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end
        if (pix_valid) begin
            frame_end = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
            emit      = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
            for (int unsigned r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb2_q[cur_col];
            win_d[1][2] = lb1_q[cur_col];
            win_d[2][2] = pix_in;
            if (emit) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    for (int unsigned c = 0; c < 3; c++) begin
                        win_data_d[(8 - (r * 3 + c)) * DATA_W +: DATA_W] = win_d[r][c];
                    end
                end
            end
        end
        win_valid_d  = emit;
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            frame_done_q <= 1'b0;
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            win_data_q   <= win_data_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Line buffers carry no reset; the row >= 2 gate hides any stale content
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb2_q[cur_col] <= lb1_q[cur_col];
            lb1_q[cur_col] <= pix_in;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign frame_done = frame_done_q;

`ifdef WINGEN_LAST_EN
    logic win_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_last_q <= 1'b0;
        end else begin
            win_last_q <= emit && frame_end;
        end
    end

    assign win_last = win_last_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized self-checking bench for conv_window_gen on a 5x5 image, against an image-array reference.
// Covers win_last as well when WINGEN_LAST_EN is defined.
module tb_conv_window_gen;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int DW = 16;
    localparam int WW = 9 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic          win_valid;
    logic [WW-1:0] win_data;
    logic          frame_done;
`ifdef WINGEN_LAST_EN
    logic          win_last;
`endif

    conv_window_gen #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .frame_done (frame_done)
`ifdef WINGEN_LAST_EN
        ,
        .win_last   (win_last)
`endif
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            mr = 0, mc = 0;
    int            win_cnt = 0;
    logic [DW-1:0] pix_mem [H][W];
    logic [WW-1:0] exp_hold = '0;

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Reference: image array of the latest value written at each (r,c); a window is
    // simply the 3x3 block of that array ending at the accepted pixel.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit c);
        logic          exp_v, exp_fd, exp_last;
        logic [WW-1:0] exp_d;
        @(negedge clk);
        pix_valid = v;
        pix_in    = d;
        clr       = c;
        exp_v = 1'b0; exp_fd = 1'b0; exp_last = 1'b0; exp_d = exp_hold;
        if (c) begin
            mr = 0;
            mc = 0;
        end
        if (v) begin
            pix_mem[mr][mc] = d;
            if (mr >= 2 && mc >= 2) begin
                exp_v = 1'b1;
                for (int k = 0; k < 9; k++)
                    exp_d[(8 - k) * DW +: DW] = pix_mem[mr - 2 + k / 3][mc - 2 + k % 3];
            end
            if (mr == H - 1 && mc == W - 1) begin
                exp_fd   = 1'b1;
                exp_last = 1'b1;
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        clr       = 1'b0;
        if (win_valid === 1'b1) win_cnt++;
        chk("win_valid", WW'(win_valid), WW'(exp_v));
        chk(exp_v ? "win_data" : "win_hold", win_data, exp_d);
        chk("frame_done", WW'(frame_done), WW'(exp_fd));
`ifdef WINGEN_LAST_EN
        chk("win_last", WW'(win_last), WW'(exp_last));
`endif
        exp_hold = exp_d;
    endtask

    task automatic send_frame(input int base, input int max_gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                cycle(1'b1, DW'(base + 16 * r + c), 1'b0);
                for (int g = $urandom_range(max_gap, 0); g > 0; g--) cycle(1'b0, DW'($urandom), 1'b0);
            end
    endtask

    initial begin
        #1;
        chk("rst_valid", WW'(win_valid), '0);
        chk("rst_data", win_data, '0);
        chk("rst_fdone", WW'(frame_done), '0);
        @(negedge clk);
        rst = 1'b0;

        // Continuous frame, then with random gaps
        win_cnt = 0;
        send_frame(0, 0);
        chk("cnt_cont", WW'(win_cnt), WW'(9));
        win_cnt = 0;
        send_frame(0, 3);
        chk("cnt_gaps", WW'(win_cnt), WW'(9));

        // Two back-to-back frames, second offset by 100
        send_frame(0, 0);
        win_cnt = 0;
        send_frame(100, 0);
        chk("cnt_b2b", WW'(win_cnt), WW'(9));

        // clr with pixel (3,1), which becomes (0,0) of a fresh frame
        for (int p = 0; p < 16; p++) cycle(1'b1, DW'(16 * (p / 5) + p % 5), 1'b0);
        win_cnt = 0;
        for (int p = 0; p < 25; p++) cycle(1'b1, DW'(300 + 16 * (p / 5) + p % 5), p == 0);
        chk("cnt_clr", WW'(win_cnt), WW'(9));

        // Asynchronous reset in the middle of the window stream
        for (int p = 0; p < 13; p++) cycle(1'b1, DW'(16 * (p / 5) + p % 5), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", WW'(win_valid), '0);
        chk("mid_rst_data", win_data, '0);
        @(negedge clk);
        rst = 1'b0;
        mr = 0; mc = 0; exp_hold = '0;
        win_cnt = 0;
        send_frame(500, 1);
        chk("cnt_after_rst", WW'(win_cnt), WW'(9));

        // Random data, random gaps, occasional clr
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(3, 0) != 0), DW'($urandom), ($urandom_range(40, 0) == 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
